// File: rtl/gol_step_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gol_step_scheduler
// Description : Launches Game of Life generations in vertical blanking and
//               arbitrates the cell-memory port between display and engine.
//               Optional BUSY watchdog: define GOL_SCHED_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gol_step_scheduler #(
  parameter int V_ACTIVE = 480,
  parameter int GEN_W    = 16
`ifdef GOL_SCHED_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 840000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       counter_x,
  input  logic [9:0]       counter_y,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       rate,
  input  logic             clr_overrun,
  input  logic             eng_done,
  output logic             eng_start,
  output logic             mem_sel,
  output logic             vid_mute,
  output logic             overrun,
  output logic             frame_tick,
  output logic [GEN_W-1:0] generation
`ifdef GOL_SCHED_WATCHDOG_EN
  ,
  output logic             eng_abort
`endif
);

  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_blank;
  logic [3:0] r_frame_cnt;
  logic       r_step_pend;
  logic       w_rate_hit;
  logic       w_launch;
  logic       w_busy_active;
  logic       w_ovr_set;
  logic       w_timeout;

  // Free-run hit and pending single-step both qualify the current frame.
  assign w_rate_hit    = frame_tick && run && (r_frame_cnt == rate);
  assign w_launch      = (r_state == S_IDLE) && frame_tick && (w_rate_hit || r_step_pend);
  assign w_busy_active = (r_state == S_BUSY) && !r_blank;
  assign w_ovr_set     = w_busy_active || w_timeout;

  assign mem_sel   = (r_state == S_GRANT) || (r_state == S_BUSY);
  assign eng_start = (r_state == S_GRANT);
  assign vid_mute  = w_busy_active;

`ifdef GOL_SCHED_WATCHDOG_EN
  localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(WDOG_CYCLES - 1);

  logic [c_wdog_w-1:0] r_wdog_cnt;

  // A completion arriving on the timeout cycle takes precedence over the abort.
  assign w_timeout = (r_state == S_BUSY) && (r_wdog_cnt == c_wdog_last) && !eng_done;
  assign eng_abort = w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_wdog_cnt <= r_wdog_cnt + c_wdog_w'(1);
    end else begin
      r_wdog_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_launch) w_state_nxt = S_GRANT;
      S_GRANT:   w_state_nxt = S_BUSY;
      S_BUSY:    if (eng_done || w_timeout) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_blank     <= 1'b0;
      frame_tick  <= 1'b0;
      r_frame_cnt <= 4'd0;
      r_step_pend <= 1'b0;
      overrun     <= 1'b0;
      generation  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_blank    <= (counter_y >= c_v_active);
      frame_tick <= (counter_x == 10'd0) && (counter_y == c_v_active);

      // The divider keeps counting on ticks that cannot launch.
      if (!run) begin
        r_frame_cnt <= 4'd0;
      end else if (frame_tick) begin
        r_frame_cnt <= w_rate_hit ? 4'd0 : r_frame_cnt + 4'd1;
      end

      if (step) begin
        r_step_pend <= 1'b1;
      end else if (w_launch) begin
        r_step_pend <= 1'b0;
      end

      if (w_ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if ((r_state == S_BUSY) && eng_done) begin
        generation <= generation + GEN_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gol_step_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gol_step_scheduler
// Description : Directed bench for gol_step_scheduler on a shrunken raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_step_scheduler;

  localparam int V_ACT = 8;
  localparam int H_TOT = 40;
  localparam int V_TOT = 12;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  counter_x, counter_y;
  logic        run, step, clr_overrun, eng_done;
  logic [3:0]  rate;
  logic        eng_start, mem_sel, vid_mute, overrun, frame_tick;
  logic [15:0] generation;
`ifdef GOL_SCHED_WATCHDOG_EN
  logic        eng_abort;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] ax, ay;
  int frame_no = 0;
  int tick_cnt = 0;
  int st_frame = 0;
  int st_q[$];
  int eng_mode = 0;
  int eng_delay = 100;
  int eng_cnt = 0;
  bit eng_busy = 1'b0;

  always #20 clk = ~clk;

  gol_step_scheduler #(
    .V_ACTIVE(V_ACT),
    .GEN_W(16)
`ifdef GOL_SCHED_WATCHDOG_EN
    ,
    .WDOG_CYCLES(50)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .counter_x(counter_x),
    .counter_y(counter_y),
    .run(run),
    .step(step),
    .rate(rate),
    .clr_overrun(clr_overrun),
    .eng_done(eng_done),
    .eng_start(eng_start),
    .mem_sel(mem_sel),
    .vid_mute(vid_mute),
    .overrun(overrun),
    .frame_tick(frame_tick),
    .generation(generation)
`ifdef GOL_SCHED_WATCHDOG_EN
    ,
    .eng_abort(eng_abort)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge (ax/ay = counters the DUT just consumed),
  // then advance the raster and the engine model.
  task automatic cyc();
    @(negedge clk);
    ax = counter_x;
    ay = counter_y;
    if (frame_tick) tick_cnt++;
    if (eng_start) begin
      st_frame = frame_no;
      st_q.push_back(tick_cnt);
    end
    if (counter_x == 10'(H_TOT - 1)) begin
      counter_x = 10'd0;
      if (counter_y == 10'(V_TOT - 1)) begin
        counter_y = 10'd0;
        frame_no++;
      end else begin
        counter_y = counter_y + 10'd1;
      end
    end else begin
      counter_x = counter_x + 10'd1;
    end
    eng_done = 1'b0;
    if (eng_start) begin
      eng_busy = 1'b1;
      eng_cnt  = eng_delay;
    end else if (eng_busy) begin
      if (eng_mode == 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1'b1;
          eng_busy = 1'b0;
        end
      end else if (eng_mode == 1) begin
        if (counter_x == 10'd0 && counter_y == 10'd5) begin
          eng_done = 1'b1;
          eng_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!eng_start && n < 2 * FRAME) begin
      cyc();
      n++;
    end
    check_eq(tag, 32'(eng_start), 1);
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    while (mem_sel && n < FRAME) begin
      cyc();
      n++;
    end
    check_eq(tag, 32'(mem_sel), 0);
  endtask

  task automatic wait_pos(input logic [9:0] x, input logic [9:0] y);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!(ax == x && ay == y) && n < 2 * FRAME);
    check_eq("pos_reached", 32'(ax == x && ay == y), 1);
  endtask

  task automatic run_ticks(input int target);
    int n = 0;
    while (tick_cnt < target && n < 40 * FRAME) begin
      cyc();
      n++;
    end
    check_eq("ticks_reached", tick_cnt, target);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  initial begin
    int fr0;
    int n;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; rate = 4'd0;
    clr_overrun = 1'b0; eng_done = 1'b0;
    counter_x = 10'd0; counter_y = 10'd0;
    repeat (3) cyc();
    check_eq("rst_mem_sel", 32'(mem_sel), 0);
    check_eq("rst_eng_start", 32'(eng_start), 0);
    check_eq("rst_vid_mute", 32'(vid_mute), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_frame_tick", 32'(frame_tick), 0);
    check_eq("rst_generation", 32'(generation), 0);
    rst_n = 1'b1;

    // Free-run every frame
    run = 1'b1; rate = 4'd0;
    for (int g = 1; g <= 3; g++) begin
      fr0 = st_frame;
      wait_start("p1_start");
      check_eq("p1_start_x", 32'(ax), 1);
      check_eq("p1_start_y", 32'(ay), V_ACT);
      if (g > 1) check_eq("p1_frame_gap", st_frame - fr0, 1);
      wait_release("p1_release");
      check_eq("p1_generation", 32'(generation), g);
      check_eq("p1_overrun", 32'(overrun), 0);
    end

    // Every fourth frame, then pause and resume
    rate = 4'd3; tick_cnt = 0; st_q.delete();
    run_ticks(12);
    repeat (3) cyc();
    check_eq("p2_starts", st_q.size(), 3);
    check_eq("p2_start0_tick", st_q[0], 4);
    check_eq("p2_start1_tick", st_q[1], 8);
    check_eq("p2_start2_tick", st_q[2], 12);
    run_ticks(14);
    check_eq("p2_generation", 32'(generation), 6);
    run = 1'b0;
    run_ticks(22);
    check_eq("p2_paused_starts", st_q.size(), 3);
    repeat (50) cyc();
    run = 1'b1; tick_cnt = 0; st_q.delete();
    run_ticks(4);
    repeat (3) cyc();
    check_eq("p2_resume_starts", st_q.size(), 1);
    if (st_q.size() > 0) check_eq("p2_resume_tick", st_q[0], 4);
    wait_release("p2_release");
    check_eq("p2_resume_gen", 32'(generation), 7);
    run = 1'b0; rate = 4'd0;

    // Single-step: mid-frame step, then step again during GRANT
    tick_cnt = 0; st_q.delete();
    wait_pos(10'd0, 10'd2);
    pulse_step();
    wait_start("p3_start");
    check_eq("p3_start_x", 32'(ax), 1);
    check_eq("p3_start_y", 32'(ay), V_ACT);
    pulse_step();
    run_ticks(3);
    repeat (5) cyc();
    check_eq("p3_starts", st_q.size(), 2);
    if (st_q.size() > 1) check_eq("p3_second_tick", st_q[1], 2);

    // Step landing on the launch cycle stays pending
    tick_cnt = 0; st_q.delete();
    wait_pos(10'd0, 10'd2);
    pulse_step();
    n = 0;
    while (!frame_tick && n < 2 * FRAME) begin
      cyc();
      n++;
    end
    pulse_step();
    run_ticks(3);
    repeat (5) cyc();
    check_eq("p3b_starts", st_q.size(), 2);
    if (st_q.size() > 1) begin
      check_eq("p3b_first_tick", st_q[0], 1);
      check_eq("p3b_second_tick", st_q[1], 2);
    end
    wait_release("p3b_release");
    check_eq("p3_generation", 32'(generation), 11);

    // Engine overruns into the next frame's active video
    eng_mode = 1;
    wait_pos(10'd0, 10'd2);
    pulse_step();
    wait_start("p4_start");
    wait_pos(10'(H_TOT - 1), 10'(V_TOT - 1));
    check_eq("p4_mute_in_blank", 32'(vid_mute), 0);
    check_eq("p4_busy_in_blank", 32'(mem_sel), 1);
    cyc();
    check_eq("p4_mute_line0", 32'(vid_mute), 1);
    cyc();
    check_eq("p4_overrun_set", 32'(overrun), 1);
    wait_release("p4_release");
    check_eq("p4_release_line", 32'(ay), 5);
    check_eq("p4_mute_released", 32'(vid_mute), 0);
    check_eq("p4_overrun_sticky", 32'(overrun), 1);
    check_eq("p4_generation", 32'(generation), 12);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    check_eq("p4_overrun_cleared", 32'(overrun), 0);

    // Asynchronous reset in BUSY
    eng_mode = 0; run = 1'b1;
    wait_start("p5_start");
    repeat (10) cyc();
    check_eq("p5_busy", 32'(mem_sel), 1);
    rst_n = 1'b0;
    #1;
    check_eq("p5_rst_mem_sel", 32'(mem_sel), 0);
    check_eq("p5_rst_eng_start", 32'(eng_start), 0);
    check_eq("p5_rst_generation", 32'(generation), 0);
    check_eq("p5_rst_overrun", 32'(overrun), 0);
    eng_busy = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    fr0 = frame_no;
    wait_start("p5_restart");
    check_eq("p5_restart_frame", st_frame - fr0, 1);
    check_eq("p5_restart_x", 32'(ax), 1);
    wait_release("p5_release");
    check_eq("p5_generation", 32'(generation), 1);
    run = 1'b0;

`ifdef GOL_SCHED_WATCHDOG_EN
    // Engine never completes: watchdog aborts after 50 BUSY cycles
    eng_mode = 2;
    wait_pos(10'd0, 10'd2);
    pulse_step();
    wait_start("wd_start");
    n = 0;
    while (!eng_abort && n < 200) begin
      cyc();
      n++;
    end
    check_eq("wd_abort_cycle", n, 50);
    cyc();
    check_eq("wd_abort_pulse", 32'(eng_abort), 0);
    check_eq("wd_overrun", 32'(overrun), 1);
    check_eq("wd_generation", 32'(generation), 1);
    check_eq("wd_mem_sel", 32'(mem_sel), 0);
    cyc();
    check_eq("wd_idle", 32'(mem_sel | eng_start), 0);
    eng_busy = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
